tmds_encoder: RTL and testbench

- Per-channel DVI 8b/10b TMDS encoder; consumes pixel byte, display-enable and two control bits in the pixel clock domain.
- Produces one DC-balanced 10-bit symbol per clock for the 10:1 serializer.
- dvi_core instantiates three copies:
  - blue channel: ctrl = {vsync, hsync}
  - green and red channels: ctrl = 2'b00
- Two-stage pipeline; running-disparity state is held internally.

---
 rtl/dvi_pkg.sv | 27 ++
 rtl/tmds_encoder_if.sv | 31 +++
 rtl/tmds_encoder_popcount8.sv | 14 +
 rtl/tmds_encoder.sv | 105 ++++++++++
 tb/tb_tmds_encoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_pkg.sv
// Shared DVI constants: TMDS symbol width, control-period codes and disparity width.
// Imported by the TMDS encoder, its interface and its helpers.
package dvi_pkg;

    localparam int TMDS_W = 10;
    localparam int DISP_W = 5;

    typedef logic [TMDS_W-1:0] tmds_sym_t;

    localparam tmds_sym_t CTRL_CODE_00 = 10'b1101010100;
    localparam tmds_sym_t CTRL_CODE_01 = 10'b0010101011;
    localparam tmds_sym_t CTRL_CODE_10 = 10'b0101010100;
    localparam tmds_sym_t CTRL_CODE_11 = 10'b1010101011;
    localparam tmds_sym_t RESET_SYM    = CTRL_CODE_00;

    function automatic tmds_sym_t ctrl_symbol(input logic [1:0] ctrl);
        tmds_sym_t sym;
        unique case (ctrl)
            2'b00: sym = CTRL_CODE_00;
            2'b01: sym = CTRL_CODE_01;
            2'b10: sym = CTRL_CODE_10;
            2'b11: sym = CTRL_CODE_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-side inputs and symbol-side outputs of one TMDS channel encoder.
// Clock and reset stay as plain ports on the encoder.
interface tmds_encoder_if
    import dvi_pkg::*;
#(
    parameter int CNT_W = DISP_W
) ();

    logic                    de_i;
    logic [7:0]              data_i;
    logic [1:0]              ctrl_i;
    logic [TMDS_W-1:0]       tmds_o;
    logic signed [CNT_W-1:0] disp_o;

    modport master (
        output de_i,
        output data_i,
        output ctrl_i,
        input  tmds_o,
        input  disp_o
    );

    modport slave (
        input  de_i,
        input  data_i,
        input  ctrl_i,
        output tmds_o,
        output disp_o
    );

endinterface

// File: rtl/tmds_encoder_popcount8.sv
// Combinational ones count of an 8-bit vector (0..8 in a 4-bit result).
module popcount8 (
    input  logic [7:0] bits,
    output logic [3:0] ones
);

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ones = ones + 4'(bits[i]);
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// DVI 8b/10b TMDS channel encoder: stage 1 minimises transitions (q_m),
// stage 2 applies DC balancing against the running disparity or emits a control code.
module tmds_encoder
    import dvi_pkg::*;
#(
    parameter int CNT_W = DISP_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    tmds_encoder_if.slave bus
);

    localparam int                      MSB = CNT_W - 1;
    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic       use_xnor;
    logic [3:0] n1_data;
    logic [8:0] q_m_d;

    logic [8:0] q_m_s1;
    logic       de_s1;
    logic [1:0] ctrl_s1;

    logic [3:0]              n1_qm;
    logic [3:0]              n0_qm;
    logic signed [CNT_W-1:0] n1_s;
    logic signed [CNT_W-1:0] n0_s;
    logic signed [CNT_W-1:0] bal;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_nxt;
    tmds_sym_t               sym_q;
    tmds_sym_t               sym_nxt;

    popcount8 u_pc_data (
        .bits (bus.data_i),
        .ones (n1_data)
    );

    assign use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !bus.data_i[0]);

    always_comb begin
        q_m_d    = '0;
        q_m_d[0] = bus.data_i[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ bus.data_i[i])
                                :  (q_m_d[i-1] ^ bus.data_i[i]);
        end
        q_m_d[8] = ~use_xnor;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_m_s1  <= '0;
            de_s1   <= 1'b0;
            ctrl_s1 <= '0;
        end else begin
            q_m_s1  <= q_m_d;
            de_s1   <= bus.de_i;
            ctrl_s1 <= bus.ctrl_i;
        end
    end

    popcount8 u_pc_qm (
        .bits (q_m_s1[7:0]),
        .ones (n1_qm)
    );

    assign n0_qm = 4'd8 - n1_qm;
    assign n1_s  = CNT_W'(n1_qm);
    assign n0_s  = CNT_W'(n0_qm);
    assign bal   = n1_s - n0_s;

    always_comb begin
        sym_nxt = RESET_SYM;
        cnt_nxt = '0;
        if (!de_s1) begin
            sym_nxt = ctrl_symbol(ctrl_s1);
            cnt_nxt = '0;
        end else if ((cnt == '0) || (bal == '0)) begin
            sym_nxt = {~q_m_s1[8], q_m_s1[8], q_m_s1[8] ? q_m_s1[7:0] : ~q_m_s1[7:0]};
            cnt_nxt = q_m_s1[8] ? (cnt + bal) : (cnt - bal);
        end else if (cnt[MSB] == bal[MSB]) begin
            // both non-zero here, so equal sign bits mean the byte would push disparity further
            sym_nxt = {1'b1, q_m_s1[8], ~q_m_s1[7:0]};
            cnt_nxt = cnt + (q_m_s1[8] ? TWO : '0) - bal;
        end else begin
            sym_nxt = {1'b0, q_m_s1[8], q_m_s1[7:0]};
            cnt_nxt = cnt - (q_m_s1[8] ? '0 : TWO) + bal;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sym_q <= RESET_SYM;
            cnt   <= '0;
        end else begin
            sym_q <= sym_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.tmds_o = sym_q;
    assign bus.disp_o = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed literal vectors, async-reset checks and a random soak
// compared every cycle against a behavioural TMDS model.
module tb_tmds_encoder;

    localparam int CNT_W = 5;

    typedef struct {
        bit       de;
        bit [7:0] data;
        bit [1:0] ctrl;
    } in_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tmds_encoder_if #(.CNT_W(CNT_W)) bus ();

    tmds_encoder #(.CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    in_t      pend[$];
    bit [9:0] exp_sym;
    int       exp_cnt;
    bit       exp_de;
    bit [7:0] exp_byte;
    int       model_cnt;

    in_t      dir_in[$];
    bit [9:0] dir_sym[$];
    int       dir_disp[$];

    function automatic void check(string nm, int act, int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h (%0d) required 0x%0h (%0d) at %0t", nm, act, act, req, req, $time);
        end
    endfunction

    function automatic bit [9:0] ctrl_sym(bit [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // q_m[i] is the parity of D[0..i]; the XNOR variant flips every odd position
    function automatic bit [8:0] minimise(bit [7:0] d);
        bit [8:0] q;
        bit [7:0] m;
        int       n;
        bit       xn;
        n  = $countones(d);
        xn = (n > 4) || (n == 4 && !d[0]);
        for (int i = 0; i < 8; i++) begin
            m    = 8'((1 << (i + 1)) - 1);
            q[i] = (^(d & m)) ^ (xn && (i % 2 == 1));
        end
        q[8] = !xn;
        return q;
    endfunction

    function automatic bit [7:0] decode(bit [9:0] s);
        bit [7:0] d;
        bit [7:0] b;
        d    = s[9] ? ~s[7:0] : s[7:0];
        b[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return b;
    endfunction

    function automatic void model_encode(in_t e);
        bit [8:0] qm;
        int       n1;
        int       n0;
        bit       inv;
        if (!e.de) begin
            exp_sym   = ctrl_sym(e.ctrl);
            model_cnt = 0;
        end else begin
            qm = minimise(e.data);
            n1 = $countones(qm[7:0]);
            n0 = 8 - n1;
            if (model_cnt == 0 || n1 == n0)
                inv = !qm[8];
            else
                inv = (model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1);
            exp_sym   = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
            model_cnt = model_cnt + 2 * $countones(exp_sym) - 10;
        end
        exp_de   = e.de;
        exp_byte = e.data;
        exp_cnt  = model_cnt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            pend.push_back('{de: 1'b0, data: 8'h00, ctrl: 2'b00});
            model_cnt = 0;
            exp_sym   = 10'b1101010100;
            exp_cnt   = 0;
            exp_de    = 1'b0;
            exp_byte  = 8'h00;
        end else begin
            if (pend.size() == 0)
                pend.push_back('{de: 1'b0, data: 8'h00, ctrl: 2'b00});
            model_encode(pend.pop_front());
            pend.push_back('{de: bus.de_i, data: bus.data_i, ctrl: bus.ctrl_i});
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int d;
            d = int'($signed(bus.disp_o));
            check("symbol", int'(bus.tmds_o), int'(exp_sym));
            check("disparity", d, exp_cnt);
            check("disparity_bound", int'(d <= 10 && d >= -10), 1);
            if (exp_de)
                check("decode", int'(decode(bus.tmds_o)), int'(exp_byte));
        end
    end

    task automatic drive(input bit de, input bit [7:0] data, input bit [1:0] ctrl);
        bus.de_i   = de;
        bus.data_i = data;
        bus.ctrl_i = ctrl;
    endtask

    task automatic add_dir(input bit de, input bit [7:0] data, input bit [1:0] ctrl,
                           input bit [9:0] sym, input int disp);
        dir_in.push_back('{de: de, data: data, ctrl: ctrl});
        dir_sym.push_back(sym);
        dir_disp.push_back(disp);
    endtask

    task automatic run_dir();
        for (int i = 0; i < dir_in.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("dir_symbol", int'(bus.tmds_o), int'(dir_sym[i-2]));
                check("dir_disparity", int'($signed(bus.disp_o)), dir_disp[i-2]);
            end
            if (i < dir_in.size())
                drive(dir_in[i].de, dir_in[i].data, dir_in[i].ctrl);
            else
                drive(1'b0, 8'h00, 2'b00);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_symbol", int'(bus.tmds_o), int'(10'b1101010100));
        check("async_rst_disparity", int'($signed(bus.disp_o)), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 8'h00, 2'b00);
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            drive(1'($urandom), 8'($urandom), 2'($urandom));
        end
        @(negedge clk);
        check("rst_symbol", int'(bus.tmds_o), int'(10'b1101010100));
        check("rst_disparity", int'($signed(bus.disp_o)), 0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 2'b00);
        check_en = 1'b1;

        add_dir(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
        add_dir(1'b0, 8'h00, 2'b01, 10'b0010101011, 0);
        add_dir(1'b0, 8'h00, 2'b10, 10'b0101010100, 0);
        add_dir(1'b0, 8'h00, 2'b11, 10'b1010101011, 0);
        add_dir(1'b1, 8'h00, 2'b11, 10'b0100000000, -8);
        add_dir(1'b1, 8'h00, 2'b01, 10'b1111111111, 2);
        add_dir(1'b1, 8'h00, 2'b10, 10'b0100000000, -6);
        add_dir(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
        add_dir(1'b1, 8'h00, 2'b00, 10'b0100000000, -8);
        add_dir(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
        add_dir(1'b1, 8'hFF, 2'b00, 10'b1000000000, -8);
        add_dir(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
        run_dir();

        repeat (3) begin
            @(negedge clk);
            drive(1'b1, 8'h00, 2'b00);
        end
        pulse_reset();

        for (int c = 0; c < 20000; c++) begin
            if (c % 5000 == 2500) begin
                pulse_reset();
            end else begin
                @(negedge clk);
                drive($urandom_range(0, 9) < 8, 8'($urandom), 2'($urandom));
            end
        end
        repeat (2) @(negedge clk);
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
